prog_sequencer: RTL and testbench

Program-store sequencer that drives the 8-bit CPU datapath autonomously instead of from the pins.
- Holds a small program of 16-bit instruction words: opcode[15:12], r1[11:8], byte[7:0] (byte = r2/r3 nibbles or LDB immediate).
- Issues datapath instructions over a valid/ready handshake.
- Executes control-flow opcodes internally, in the unused R-level slots 0100–0111.
- Sits between the host load interface and the decode/regfile/ALU datapath.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/prog_mem.sv | 23 ++
 rtl/prog_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_prog_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes (incl. sequencer control ops), ALU codes,
// instruction field slices and the program-sequencer state encoding.
package cpu_pkg;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int R1_HI   = 11;
  localparam int R1_LO   = 8;
  localparam int BYTE_HI = 7;
  localparam int BYTE_LO = 0;
  localparam int TGT_HI  = 3;
  localparam int TGT_LO  = 0;

  // 0100-0111 are the R-level slots reused for sequencer-internal control flow
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_JMP  = 4'b0100,
    OP_JC   = 4'b0101,
    OP_LOOP = 4'b0110,
    OP_SETL = 4'b0111,
    OP_INC  = 4'b1000,
    OP_DEC  = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_NOT  = 4'b1011,
    OP_MOV  = 4'b1100,
    OP_LDB  = 4'b1101,
    OP_SHL  = 4'b1110,
    OP_NOP  = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_INC, ALU_DEC
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DONE, S_HOLD
  } seq_state_t;

  function automatic opcode_t opc_of(logic [INSTR_W-1:0] w);
    return opcode_t'(w[OPC_HI:OPC_LO]);
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: one write port, registered read port, array not reset.
module prog_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program-store sequencer feeding the datapath over valid/ready; runs JMP/JC/
// LOOP/SETL internally. Optional SEQ_SINGLE_STEP_EN adds a step input + HOLD.
module prog_sequencer
  import cpu_pkg::*;
#(
  parameter int DEPTH_P   = DEPTH,
  parameter int ADDR_W_P  = ADDR_W,
  parameter int INSTR_W_P = INSTR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load_valid,
  input  logic [INSTR_W_P-1:0] load_data,
  output logic                 load_ready,
  input  logic                 start,
  input  logic                 halt_req,
  output logic                 issue_valid,
  output logic [INSTR_W_P-1:0] issue_instr,
  input  logic                 issue_ready,
  input  logic                 carry_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W_P-1:0]  pc
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic                 step
`endif
);

  seq_state_t            state, state_n;
  logic [ADDR_W_P:0]     prog_len;
  logic [ADDR_W_P-1:0]   pc_n;
  logic [7:0]            loop_cnt, loop_cnt_n;
  logic                  halt_pend;
  logic [INSTR_W_P-1:0]  instr;
  logic                  err_set, issue_load;
  logic                  clear_ok, start_ok, load_fire;
  logic                  halt;
  logic [ADDR_W_P:0]     pc_inc;
  logic                  seq_end;
  logic [ADDR_W_P-1:0]   tgt;
  logic                  tgt_bad;
  seq_state_t            fetch_st;

  assign busy       = (state == S_FETCH) || (state == S_DECODE) || (state == S_ISSUE);
  assign load_ready = (state == S_IDLE) && (prog_len < (ADDR_W_P+1)'(DEPTH_P));
  assign clear_ok   = clear && ((state == S_IDLE) || (state == S_DONE));
  assign start_ok   = (state == S_IDLE) && start && !clear;
  assign load_fire  = load_valid && load_ready && !clear_ok;
  assign halt       = halt_req || halt_pend;
  assign pc_inc     = {1'b0, pc} + (ADDR_W_P+1)'(1);
  assign seq_end    = (pc_inc == prog_len);
  assign tgt        = instr[TGT_HI:TGT_LO];
  assign tgt_bad    = ({1'b0, tgt} >= prog_len);

  // Every path into FETCH goes through here so single-step can gate it
`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_st = step ? S_FETCH : S_HOLD;
`else
  assign fetch_st = S_FETCH;
`endif

  prog_mem #(.DEPTH(DEPTH_P), .ADDR_W(ADDR_W_P), .W(INSTR_W_P)) u_mem (
    .clk   (clk),
    .we    (load_fire),
    .waddr (prog_len[ADDR_W_P-1:0]),
    .wdata (load_data),
    .re    (state == S_FETCH),
    .raddr (pc),
    .rdata (instr)
  );

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    loop_cnt_n = loop_cnt;
    err_set    = 1'b0;
    issue_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (prog_len != '0) begin
            state_n = fetch_st;
            pc_n    = '0;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_FETCH: state_n = halt ? S_IDLE : S_DECODE;
      S_DECODE: begin
        if (halt) begin
          state_n = S_IDLE;
        end else begin
          case (opc_of(instr))
            OP_JMP, OP_JC, OP_LOOP: begin
              if ((opc_of(instr) == OP_JMP) ||
                  (opc_of(instr) == OP_JC && carry_in) ||
                  (opc_of(instr) == OP_LOOP && loop_cnt != 8'd0)) begin
                if (tgt_bad) begin
                  err_set = 1'b1;
                  state_n = S_IDLE;
                end else begin
                  pc_n    = tgt;
                  state_n = fetch_st;
                  if (opc_of(instr) == OP_LOOP) loop_cnt_n = loop_cnt - 8'd1;
                end
              end else begin
                pc_n    = pc_inc[ADDR_W_P-1:0];
                state_n = seq_end ? S_DONE : fetch_st;
              end
            end
            OP_SETL: begin
              loop_cnt_n = instr[BYTE_HI:BYTE_LO];
              pc_n       = pc_inc[ADDR_W_P-1:0];
              state_n    = seq_end ? S_DONE : fetch_st;
            end
            default: begin
              issue_load = 1'b1;
              state_n    = S_ISSUE;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          pc_n = pc_inc[ADDR_W_P-1:0];
          if (halt)         state_n = S_IDLE;
          else if (seq_end) state_n = S_DONE;
          else              state_n = fetch_st;
        end
      end
      S_DONE: state_n = S_IDLE;
      S_HOLD: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (halt_req)  state_n = S_IDLE;
        else if (step) state_n = S_FETCH;
`else
        state_n = S_IDLE;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      prog_len    <= '0;
      loop_cnt    <= '0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      halt_pend   <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      loop_cnt <= loop_cnt_n;

      if (issue_load) begin
        issue_valid <= 1'b1;
        issue_instr <= instr;
      end else if (issue_valid && issue_ready) begin
        issue_valid <= 1'b0;
      end

      // A halt seen while stalled in ISSUE must survive until the handshake
      if (state_n == S_IDLE)     halt_pend <= 1'b0;
      else if (busy && halt_req) halt_pend <= 1'b1;

      if (clear_ok)       prog_len <= '0;
      else if (load_fire) prog_len <= prog_len + (ADDR_W_P+1)'(1);

      if (clear_ok)               done <= 1'b0;
      else if (state_n == S_DONE) done <= 1'b1;
      else if (start_ok)          done <= 1'b0;

      if (clear_ok)      err <= 1'b0;
      else if (err_set)  err <= 1'b1;
      else if (start_ok) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: load/run, stall, loops, branches, halt,
// async reset, full store and empty-program start.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        issue_valid;
  logic [15:0] issue_instr;
  logic        issue_ready = 1'b0;
  logic        carry_in = 1'b0;
  logic        busy, done, err;
  logic [3:0]  pc;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] hs_log [128];
  int          hs_cnt = 0;
  int          base;

  always #5 clk = ~clk;

  prog_sequencer dut (
    .clk(clk), .rst(rst), .clear(clear),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .halt_req(halt_req),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
    .carry_in(carry_in), .busy(busy), .done(done), .err(err), .pc(pc)
`ifdef SEQ_SINGLE_STEP_EN
    , .step(step)
`endif
  );

  always @(posedge clk)
    if (issue_valid && issue_ready && hs_cnt < 128) begin
      hs_log[hs_cnt] <= issue_instr;
      hs_cnt <= hs_cnt + 1;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    load_valid = 1'b1; load_data = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start();
    tick();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!issue_valid && n < budget) begin tick(); n++; end
    check(tag, issue_valid, 1'b1);
  endtask

  initial begin
    #12 rst = 1'b0;
    tick();
    // reset state
    check("rst_valid", issue_valid, 1'b0);
    check("rst_instr", issue_instr, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_pc", pc, 4'd0);
    check("rst_load_ready", load_ready, 1'b1);

    // 1: straight-line program
    load_word(16'hD105); load_word(16'hD203); load_word(16'h0123);
    issue_ready = 1'b1;
    base = hs_cnt;
    do_start();
    check("t1_busy", busy, 1'b1);
    wait_idle("t1_timeout", 100);
    check("t1_count", hs_cnt - base, 3);
    check("t1_i0", hs_log[base], 16'hD105);
    check("t1_i1", hs_log[base+1], 16'hD203);
    check("t1_i2", hs_log[base+2], 16'h0123);
    check("t1_done", done, 1'b1);
    check("t1_pc", pc, 4'd3);

    // 2: datapath stall keeps the request stable
    do_clear();
    check("t2_clear_done", done, 1'b0);
    load_word(16'hD105);
    issue_ready = 1'b0;
    base = hs_cnt;
    do_start();
    wait_valid("t2_valid_timeout", 20);
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", issue_valid, 1'b1);
      check("t2_stall_instr", issue_instr, 16'hD105);
      tick();
    end
    issue_ready = 1'b1;
    tick();
    check("t2_drop_valid", issue_valid, 1'b0);
    wait_idle("t2_timeout", 20);
    check("t2_count", hs_cnt - base, 1);
    check("t2_done", done, 1'b1);

    // 3: SETL 2 / INC / LOOP->1 runs the body three times
    do_clear();
    load_word(16'h7002); load_word(16'h8110); load_word(16'h6001);
    base = hs_cnt;
    do_start();
    wait_idle("t3_timeout", 100);
    check("t3_count", hs_cnt - base, 3);
    check("t3_i0", hs_log[base], 16'h8110);
    check("t3_i2", hs_log[base+2], 16'h8110);
    check("t3_done", done, 1'b1);
    check("t3_pc", pc, 4'd3);

    // 4: JC taken, JC not taken, out-of-range JMP
    do_clear();
    load_word(16'h5002); load_word(16'hD111); load_word(16'hD222);
    carry_in = 1'b1;
    base = hs_cnt;
    do_start();
    wait_idle("t4a_timeout", 50);
    check("t4a_count", hs_cnt - base, 1);
    check("t4a_i0", hs_log[base], 16'hD222);
    check("t4a_done", done, 1'b1);
    carry_in = 1'b0;
    base = hs_cnt;
    do_start();
    check("t4b_done_cleared", done, 1'b0);
    wait_idle("t4b_timeout", 50);
    check("t4b_count", hs_cnt - base, 2);
    check("t4b_i0", hs_log[base], 16'hD111);
    check("t4b_i1", hs_log[base+1], 16'hD222);
    check("t4b_pc", pc, 4'd3);
    do_clear();
    load_word(16'h400F); load_word(16'hD111); load_word(16'hD222); load_word(16'hD333);
    base = hs_cnt;
    do_start();
    wait_idle("t4c_timeout", 50);
    check("t4c_err", err, 1'b1);
    check("t4c_done", done, 1'b0);
    check("t4c_idle", load_ready, 1'b1);
    check("t4c_count", hs_cnt - base, 0);
    check("t4c_pc", pc, 4'd0);

    // 5: halt while stalled, then async reset mid-run
    do_clear();
    check("t5_err_cleared", err, 1'b0);
    load_word(16'hD105); load_word(16'hD203);
    issue_ready = 1'b0;
    base = hs_cnt;
    do_start();
    wait_valid("t5_valid_timeout", 20);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("t5_hold_valid", issue_valid, 1'b1);
    tick();
    check("t5_hold_valid2", issue_valid, 1'b1);
    check("t5_hold_busy", busy, 1'b1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("t5_halt_busy", busy, 1'b0);
    check("t5_halt_done", done, 1'b0);
    check("t5_halt_valid", issue_valid, 1'b0);
    check("t5_halt_pc", pc, 4'd1);
    check("t5_count", hs_cnt - base, 1);
    do_start();
    wait_valid("t5r_valid_timeout", 20);
    #2 rst = 1'b1;
    #1;
    check("t5r_valid", issue_valid, 1'b0);
    check("t5r_busy", busy, 1'b0);
    check("t5r_pc", pc, 4'd0);
    check("t5r_instr", issue_instr, 16'h0);
    #2 rst = 1'b0;
    tick();
    check("t5r_load_ready", load_ready, 1'b1);

    // 6: full store drops the 17th word; empty store finishes at once
    for (int i = 0; i < 16; i++) load_word(16'hD000 | 16'(i));
    check("t6_full", load_ready, 1'b0);
    load_word(16'hD0FF);
    issue_ready = 1'b1;
    base = hs_cnt;
    do_start();
    wait_idle("t6_timeout", 200);
    check("t6_count", hs_cnt - base, 16);
    check("t6_first", hs_log[base], 16'hD000);
    check("t6_last", hs_log[base+15], 16'hD00F);
    check("t6_done", done, 1'b1);
    check("t6_pc_wrap", pc, 4'd0);
    do_clear();
    check("t6_clear_ready", load_ready, 1'b1);
    base = hs_cnt;
    do_start();
    wait_idle("t6e_timeout", 10);
    check("t6e_done", done, 1'b1);
    check("t6e_count", hs_cnt - base, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
